// File: rtl/semafor_pkg.sv
// Shared types and constants for the traffic-light sequencer: phase encoding,
// lamp codes and the default phase durations.
package semafor_pkg;

   typedef enum logic [1:0] {
      ROSU   = 2'd0,
      VERDE  = 2'd1,
      GALBEN = 2'd2
   } stare_t;

   // Lamp vector order is {rosu, galben, verde}
   localparam logic [2:0] LUMINI_ROSU   = 3'b100;
   localparam logic [2:0] LUMINI_GALBEN = 3'b010;
   localparam logic [2:0] LUMINI_VERDE  = 3'b001;

   localparam int unsigned LATIME_IMPLICIT     = 6;
   localparam int unsigned SEC_ROSU_IMPLICIT   = 10;
   localparam int unsigned SEC_VERDE_IMPLICIT  = 10;
   localparam int unsigned SEC_GALBEN_IMPLICIT = 3;
   localparam int unsigned SEC_PIETON_IMPLICIT = 3;

   function automatic logic [2:0] lumini_pentru(input stare_t s);
      logic [2:0] l;
      l = LUMINI_ROSU;
      case (s)
         VERDE:   l = LUMINI_VERDE;
         GALBEN:  l = LUMINI_GALBEN;
         default: l = LUMINI_ROSU;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/controler_semafor_numarator_secunde.sv
// Loadable seconds down-counter; flags when the count sits at 1 so the
// sequencer knows the current phase is on its last second.
module numarator_secunde #(
   parameter int unsigned            LATIME    = 6,
   parameter logic [LATIME-1:0]      VAL_RESET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              incarca,
   input  logic [LATIME-1:0] valoare,
   input  logic              decrementeaza,
   output logic [LATIME-1:0] secunde,
   output logic              unu
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         secunde <= VAL_RESET;
      end else if (incarca) begin
         secunde <= valoare;
      end else if (decrementeaza) begin
         secunde <= secunde - 1'b1;
      end
   end

   assign unu = (secunde == LATIME'(1));

endmodule

// File: rtl/controler_semafor.sv
// Traffic-light sequencer ROSU -> VERDE -> GALBEN with a per-phase seconds
// countdown and a latched pedestrian request that shortens the green phase.
module controler_semafor
   import semafor_pkg::*;
#(
   parameter int unsigned LATIME     = LATIME_IMPLICIT,
   parameter int unsigned SEC_ROSU   = SEC_ROSU_IMPLICIT,
   parameter int unsigned SEC_VERDE  = SEC_VERDE_IMPLICIT,
   parameter int unsigned SEC_GALBEN = SEC_GALBEN_IMPLICIT,
   parameter int unsigned SEC_PIETON = SEC_PIETON_IMPLICIT
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable,
   input  logic              puls_1_sec,
   input  logic              cerere_pieton,
   output logic [2:0]        lumini,
   output logic [LATIME-1:0] secunde,
   output logic              cerere_memorata,
   output logic              schimbare
);

   localparam int unsigned MAX_SEC = (1 << LATIME) - 1;

   if (SEC_ROSU < 1 || SEC_ROSU > MAX_SEC || SEC_VERDE < 1 || SEC_VERDE > MAX_SEC ||
       SEC_GALBEN < 1 || SEC_GALBEN > MAX_SEC || SEC_PIETON < 1 || SEC_PIETON > MAX_SEC ||
       SEC_PIETON >= SEC_VERDE) begin : g_parametri_invalizi
      $error("controler_semafor: durations must lie in 1..2^LATIME-1 and SEC_PIETON < SEC_VERDE");
   end

   localparam logic [LATIME-1:0] V_ROSU   = LATIME'(SEC_ROSU);
   localparam logic [LATIME-1:0] V_VERDE  = LATIME'(SEC_VERDE);
   localparam logic [LATIME-1:0] V_GALBEN = LATIME'(SEC_GALBEN);
   localparam logic [LATIME-1:0] V_PIETON = LATIME'(SEC_PIETON);

   stare_t            stare, stare_urm;
   logic              tick;
   logic              unu;
   logic              incarca;
   logic              decrementeaza;
   logic [LATIME-1:0] valoare;
   logic              schimbare_urm;
   logic              cerere_urm;

   assign tick = puls_1_sec & enable;

   numarator_secunde #(
      .LATIME    (LATIME),
      .VAL_RESET (V_ROSU)
   ) u_numarator (
      .clk           (clk_i),
      .rst           (reset_i),
      .incarca       (incarca),
      .valoare       (valoare),
      .decrementeaza (decrementeaza),
      .secunde       (secunde),
      .unu           (unu)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stare           <= ROSU;
         lumini          <= LUMINI_ROSU;
         cerere_memorata <= 1'b0;
         schimbare       <= 1'b0;
      end else begin
         stare           <= stare_urm;
         lumini          <= lumini_pentru(stare_urm);
         cerere_memorata <= cerere_urm;
         schimbare       <= schimbare_urm;
      end
   end

   always_comb begin
      stare_urm     = stare;
      incarca       = 1'b0;
      decrementeaza = 1'b0;
      valoare       = V_ROSU;
      schimbare_urm = 1'b0;
      // The clear on red entry takes priority over a request in the same cycle
      cerere_urm    = cerere_memorata | cerere_pieton;
      if (tick) begin
         if (unu) begin
            incarca       = 1'b1;
            schimbare_urm = 1'b1;
            case (stare)
               ROSU: begin
                  stare_urm = VERDE;
                  valoare   = V_VERDE;
               end
               VERDE: begin
                  stare_urm = GALBEN;
                  valoare   = V_GALBEN;
               end
               default: begin
                  stare_urm  = ROSU;
                  valoare    = V_ROSU;
                  cerere_urm = 1'b0;
               end
            endcase
         end else if (stare == VERDE && cerere_memorata && secunde > V_PIETON) begin
            incarca = 1'b1;
            valoare = V_PIETON;
         end else begin
            decrementeaza = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_controler_semafor.sv
// Directed bench for controler_semafor with short phase durations.
module tb_controler_semafor;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       enable = 1'b1;
   logic       puls_1_sec = 1'b0;
   logic       cerere_pieton = 1'b0;
   logic [2:0] lumini;
   logic [5:0] secunde;
   logic       cerere_memorata;
   logic       schimbare;

   int vectori = 0;
   int erori = 0;
   int nr_schimbari;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] V = 3'b001;
   localparam logic [2:0] G = 3'b010;

   controler_semafor #(
      .LATIME     (6),
      .SEC_ROSU   (4),
      .SEC_VERDE  (5),
      .SEC_GALBEN (2),
      .SEC_PIETON (2)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .enable          (enable),
      .puls_1_sec      (puls_1_sec),
      .cerere_pieton   (cerere_pieton),
      .lumini          (lumini),
      .secunde         (secunde),
      .cerere_memorata (cerere_memorata),
      .schimbare       (schimbare)
   );

   always #5 clk_i = ~clk_i;

   task automatic verifica(input string nume, input int obs, input int asteptat);
      vectori++;
      if (obs !== asteptat) begin
         erori++;
         $display("FAIL %s: got %0d, expected %0d", nume, obs, asteptat);
      end
   endtask

   task automatic pas(input logic p, input logic c);
      @(negedge clk_i);
      puls_1_sec    = p;
      cerere_pieton = c;
      @(posedge clk_i);
      #1;
      if (schimbare === 1'b1) nr_schimbari++;
   endtask

   task automatic iesiri(input string nume, input logic [2:0] l, input int s, input logic sch);
      verifica({nume, ".lumini"}, int'(lumini), int'(l));
      verifica({nume, ".secunde"}, int'(secunde), s);
      verifica({nume, ".schimbare"}, int'(schimbare), int'(sch));
   endtask

   // Expected per-tick values for a full cycle without requests
   int         sec_ciclu [11] = '{3, 2, 1, 5, 4, 3, 2, 1, 2, 1, 4};
   logic [2:0] lum_ciclu [11] = '{R, R, R, V, V, V, V, V, G, G, R};
   logic       sch_ciclu [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1};

   initial begin
      nr_schimbari = 0;
      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      iesiri("reset", R, 4, 1'b0);
      verifica("reset.cerere", int'(cerere_memorata), 0);
      repeat (3) pas(1'b0, 1'b0);
      iesiri("idle", R, 4, 1'b0);
      verifica("idle.cerere", int'(cerere_memorata), 0);

      // Full cycle without a pedestrian request
      nr_schimbari = 0;
      for (int i = 0; i < 11; i++) begin
         pas(1'b1, 1'b0);
         iesiri($sformatf("ciclu[%0d]", i), lum_ciclu[i], sec_ciclu[i], sch_ciclu[i]);
      end
      verifica("ciclu.nr_schimbari", nr_schimbari, 3);
      pas(1'b0, 1'b0);
      iesiri("ciclu.dupa", R, 4, 1'b0);

      // Request at the start of green shortens it to 2
      repeat (4) pas(1'b1, 1'b0);
      iesiri("p1.verde", V, 5, 1'b1);
      pas(1'b0, 1'b1);
      verifica("p1.cerere_set", int'(cerere_memorata), 1);
      iesiri("p1.asteapta", V, 5, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p1.scurtat", V, 2, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p1.unu", V, 1, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p1.galben", G, 2, 1'b1);
      verifica("p1.cerere_galben", int'(cerere_memorata), 1);
      pas(1'b1, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p1.rosu", R, 4, 1'b1);
      verifica("p1.cerere_sters", int'(cerere_memorata), 0);

      // Late request in green: no shortening, held until red entry
      repeat (4) pas(1'b1, 1'b0);
      repeat (3) pas(1'b1, 1'b0);
      iesiri("p2.verde2", V, 2, 1'b0);
      pas(1'b0, 1'b1);
      verifica("p2.cerere_set", int'(cerere_memorata), 1);
      pas(1'b1, 1'b0);
      iesiri("p2.fara_scurtare", V, 1, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p2.galben", G, 2, 1'b1);
      verifica("p2.cerere_persista", int'(cerere_memorata), 1);
      pas(1'b1, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p2.rosu", R, 4, 1'b1);
      verifica("p2.cerere_sters", int'(cerere_memorata), 0);

      // Request during red shortens the next green 5 -> 2
      pas(1'b1, 1'b1);
      iesiri("p3.rosu3", R, 3, 1'b0);
      verifica("p3.cerere_set", int'(cerere_memorata), 1);
      repeat (3) pas(1'b1, 1'b0);
      iesiri("p3.verde", V, 5, 1'b1);
      pas(1'b1, 1'b0);
      iesiri("p3.scurtat", V, 2, 1'b0);
      pas(1'b1, 1'b0);
      pas(1'b1, 1'b0);
      iesiri("p3.galben", G, 2, 1'b1);
      pas(1'b1, 1'b0);
      iesiri("p3.galben1", G, 1, 1'b0);

      // Request coincident with the GALBEN -> ROSU tick is dropped
      pas(1'b1, 1'b1);
      iesiri("p4.rosu", R, 4, 1'b1);
      verifica("p4.cerere_coincidenta", int'(cerere_memorata), 0);
      pas(1'b0, 1'b0);
      verifica("p4.cerere_ramane0", int'(cerere_memorata), 0);

      // Ticks with enable low are discarded
      enable = 1'b0;
      repeat (3) pas(1'b1, 1'b0);
      iesiri("en0", R, 4, 1'b0);
      enable = 1'b1;
      repeat (4) pas(1'b1, 1'b0);
      repeat (2) pas(1'b1, 1'b0);
      iesiri("rst.verde3", V, 3, 1'b0);

      // Asynchronous reset mid-green, checked before the next clock edge
      @(negedge clk_i);
      puls_1_sec = 1'b0;
      reset_i = 1'b1;
      #1;
      iesiri("rst.async", R, 4, 1'b0);
      verifica("rst.cerere", int'(cerere_memorata), 0);
      @(negedge clk_i);
      reset_i = 1'b0;

      // Request is latched even while enable is low
      enable = 1'b0;
      pas(1'b0, 1'b1);
      verifica("en0.cerere_set", int'(cerere_memorata), 1);
      iesiri("en0.cerere", R, 4, 1'b0);
      pas(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectori, erori);
      $finish;
   end

endmodule
